// File: rtl/secam_fm_modulator.sv
// SECAM FM chroma modulator: clamped deviation, aligned phase increment, ramped envelope.
// Define SECAM_PHASE_SEQUENCE_EN to enable the line/frame carrier phase loads.
module secam_fm_modulator #(
  parameter int ACC_W       = 51,
  parameter int PHASE_W     = 5,
  parameter int AMPL_W      = 6,
  parameter int DEV_W       = 13,
  parameter int DEV_SHIFT   = 35,
  parameter int DEV_MAX     = 2047,
  parameter logic [ACC_W-1:0] DB_INC = '0,
  parameter logic [ACC_W-1:0] DR_INC = '0,
  parameter int DELAY_DEPTH = 32,
  parameter int RAMP_STEP   = 4,
  localparam int LAT_W      = $clog2(DELAY_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_start,
  input  logic                    frame_start,
  input  logic                    even_line,
  input  logic                    enabled,
  input  logic signed [DEV_W-1:0] dev_in,
  input  logic [AMPL_W-1:0]       ampl_in,
  input  logic [LAT_W-1:0]        latency,
  output logic [ACC_W-1:0]        phase_inc_ampl,
  output logic [PHASE_W-1:0]      carrier_phase,
  output logic [AMPL_W-1:0]       carrier_amplitude
);

  localparam logic signed [DEV_W-1:0] DEV_HI = DEV_W'(DEV_MAX);
  localparam logic signed [DEV_W-1:0] DEV_LO = -DEV_HI;
  localparam logic [AMPL_W-1:0]       STEP   = AMPL_W'(RAMP_STEP);
  localparam logic [AMPL_W:0]         STEP_X = (AMPL_W+1)'(RAMP_STEP);
  localparam logic [LAT_W:0]          FILL_FULL = (LAT_W+1)'(DELAY_DEPTH);

  typedef enum logic [1:0] {IDLE, RAMP_UP, ACTIVE, RAMP_DOWN} env_state_t;

  function automatic logic [ACC_W-1:0] inc_of(input logic signed [DEV_W-1:0] dev,
                                               input logic db_line);
    logic signed [ACC_W-1:0] dev_x;
    dev_x = ACC_W'(dev);
    dev_x = dev_x <<< DEV_SHIFT;
    return db_line ? DB_INC + dev_x : DR_INC - dev_x;
  endfunction

  logic signed [DEV_W-1:0] dev_c_d, dev_c_q, dev_dly;
  logic                    even_c_q;
  logic signed [DEV_W-1:0] ring_q [DELAY_DEPTH];
  logic [LAT_W-1:0]        wr_ptr_d, wr_ptr_q, rd_ptr;
  logic [LAT_W:0]          fill_d, fill_q;
  logic [ACC_W-1:0]        phase_inc_d, phase_inc_q, pia_d, pia_q;
  logic [ACC_W-1:0]        acc_d, acc_q, load_val;
  logic                    load;
  logic [PHASE_W-1:0]      cp_d, cp_q;
  env_state_t              state_d, state_q;
  logic [AMPL_W-1:0]       env_d, env_q;
  logic [AMPL_W:0]         env_up;

  always_comb begin
    dev_c_d = '0;
    if (enabled) begin
      if (dev_in > DEV_HI)      dev_c_d = DEV_HI;
      else if (dev_in < DEV_LO) dev_c_d = DEV_LO;
      else                      dev_c_d = dev_in;
    end
  end

  // Taps not yet written since reset read as zero, so stale ring contents never leak.
  always_comb begin
    wr_ptr_d = wr_ptr_q + 1'b1;
    fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    rd_ptr   = wr_ptr_q - latency;
    if (latency == '0)
      dev_dly = dev_c_q;
    else if ({1'b0, latency} <= fill_q)
      dev_dly = ring_q[rd_ptr];
    else
      dev_dly = '0;
    pia_d       = inc_of(dev_c_q, even_c_q);
    phase_inc_d = inc_of(dev_dly, even_c_q);
    acc_d       = load ? load_val : acc_q + phase_inc_q;
    cp_d        = acc_q[ACC_W-1 -: PHASE_W];
  end

`ifdef SECAM_PHASE_SEQUENCE_EN
  logic [1:0] line_mod3_d, line_mod3_q, line_idx;
  logic       frame_odd_d, frame_odd_q;

  // A coincident frame_start resets the count first, so this line counts as line 0.
  always_comb begin
    line_idx    = frame_start ? 2'd0 : line_mod3_q;
    frame_odd_d = frame_odd_q ^ frame_start;
    line_mod3_d = line_idx;
    if (line_start) line_mod3_d = (line_idx == 2'd2) ? 2'd0 : line_idx + 2'd1;
    load     = line_start;
    load_val = '0;
    load_val[ACC_W-1] = (line_idx == 2'd2) ^ frame_odd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_mod3_q <= '0;
      frame_odd_q <= 1'b0;
    end else begin
      line_mod3_q <= line_mod3_d;
      frame_odd_q <= frame_odd_d;
    end
  end
`else
  logic unused_seq_in;
  assign unused_seq_in = line_start ^ frame_start;
  assign load          = 1'b0;
  assign load_val      = '0;
`endif

  // Envelope holds for the cycle in which the state changes direction.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    env_up  = {1'b0, env_q} + STEP_X;
    case (state_q)
      IDLE: begin
        env_d = '0;
        if (enabled) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enabled) state_d = RAMP_DOWN;
        else if (env_up >= {1'b0, ampl_in}) begin
          env_d   = ampl_in;
          state_d = ACTIVE;
        end else env_d = env_up[AMPL_W-1:0];
      end
      ACTIVE: begin
        if (!enabled) state_d = RAMP_DOWN;
        else          env_d = ampl_in;
      end
      RAMP_DOWN: begin
        if (enabled) state_d = RAMP_UP;
        else if (env_q <= STEP) begin
          env_d   = '0;
          state_d = IDLE;
        end else env_d = env_q - STEP;
      end
      default: begin
        state_d = IDLE;
        env_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dev_c_q     <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      pia_q       <= '0;
      phase_inc_q <= '0;
      acc_q       <= '0;
      cp_q        <= '0;
      state_q     <= IDLE;
      env_q       <= '0;
    end else begin
      dev_c_q     <= dev_c_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      pia_q       <= pia_d;
      phase_inc_q <= phase_inc_d;
      acc_q       <= acc_d;
      cp_q        <= cp_d;
      state_q     <= state_d;
      env_q       <= env_d;
    end
  end

  always_ff @(posedge clk) begin
    even_c_q          <= even_line;
    ring_q[wr_ptr_q]  <= dev_c_q;
  end

  assign phase_inc_ampl    = pia_q;
  assign carrier_phase     = cp_q;
  assign carrier_amplitude = env_q;

endmodule

// File: tb/tb_secam_fm_modulator.sv
// Scoreboard bench for secam_fm_modulator: stimulus queues expected values per cycle.
module tb_secam_fm_modulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               line_start = 1'b0, frame_start = 1'b0;
  logic               even_line = 1'b1, enabled = 1'b0;
  logic signed [12:0] dev_in = '0;
  logic [5:0]         ampl_in = 6'd20;
  logic [4:0]         latency = '0;
  logic [15:0]        phase_inc_ampl;
  logic [4:0]         carrier_phase;
  logic [5:0]         carrier_amplitude;

  secam_fm_modulator #(
    .ACC_W(16), .PHASE_W(5), .AMPL_W(6), .DEV_W(13), .DEV_SHIFT(4), .DEV_MAX(100),
    .DB_INC(16'h1000), .DR_INC(16'h1200), .DELAY_DEPTH(32), .RAMP_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .frame_start(frame_start),
    .even_line(even_line), .enabled(enabled), .dev_in(dev_in), .ampl_in(ampl_in),
    .latency(latency), .phase_inc_ampl(phase_inc_ampl), .carrier_phase(carrier_phase),
    .carrier_amplitude(carrier_amplitude)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sel; int exp; string name; } chk_t;
  chk_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Clamp/increment vectors: even_line, dev_in, enabled, expected phase_inc_ampl
  int b_even[10] = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  int b_dev [10] = '{500, -500, 50, -50, 500, -4096, 100, 99, -100, 0};
  int b_en  [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  int b_exp [10] = '{'h1640, 'h1840, 'h0EE0, 'h0CE0, 'h1000, 'h09C0, 'h1640, 'h0BD0, 'h1840, 'h1200};

  // Envelope: offset from release, expected carrier_amplitude
  int d_off[22] = '{2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24};
  int d_exp[22] = '{4, 8, 12, 12, 8, 4, 0, 0, 0, 4, 8, 12, 12, 8, 4, 4, 8, 12, 16, 20, 20, 10};

  // Phase sequence: offset from release, expected carrier_phase
  int e_off[10] = '{6, 9, 12, 13, 15, 18, 21, 25, 28, 31};
`ifdef SECAM_PHASE_SEQUENCE_EN
  int e_exp[10] = '{0, 0, 16, 18, 0, 0, 16, 16, 16, 0};
`else
  int e_exp[10] = '{8, 14, 20, 22, 26, 0, 6, 14, 20, 26};
`endif

  function automatic int actual(input int sel);
    case (sel)
      0:       return int'(phase_inc_ampl);
      1:       return int'(carrier_phase);
      default: return int'(carrier_amplitude);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input int sel, input int exp, input string name);
    chk_t e;
    e.cyc = c; e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_reset(output int t0);
    rst = 1'b1; enabled = 1'b0; even_line = 1'b1; dev_in = '0; latency = '0;
    line_start = 1'b0; frame_start = 1'b0; ampl_in = 6'd20;
    tick();
    tick();
    rst = 1'b0;
    t0 = cyc;
    push(t0, 0, 0, "rst_phase_inc_ampl");
    push(t0, 1, 0, "rst_carrier_phase");
    push(t0, 2, 0, "rst_carrier_amplitude");
  endtask

  task automatic pulse(input logic ls, input logic fs);
    line_start = ls; frame_start = fs;
    tick();
    line_start = 1'b0; frame_start = 1'b0;
  endtask

  initial begin : monitor
    int i;
    int act;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc <= cyc) begin
          n_cmp++;
          act = actual(sb[i].sel);
          if (sb[i].cyc < cyc) begin
            n_err++;
            $display("FAIL %s: check for cycle %0d expired at cycle %0d, required 0x%0h",
                     sb[i].name, sb[i].cyc, cyc, sb[i].exp);
          end else if (act != sb[i].exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: actual 0x%0h required 0x%0h",
                     sb[i].name, cyc, act, sb[i].exp);
          end
          sb.delete(i);
        end else i++;
      end
    end
  end

  initial begin : stimulus
    int t0;

    // Rest Db carrier and envelope ramp to 20
    do_reset(t0);
    enabled = 1'b1; even_line = 1'b1; dev_in = '0; ampl_in = 6'd20;
    push(t0 + 1, 0, 'h1000, "rest_db_inc");
    for (int k = 0; k < 5; k++) push(t0 + 2 + k, 2, 4 * (k + 1), "ramp_up");
    push(t0 + 8, 2, 20, "ramp_hold");
    push(t0 + 3, 1, 2, "rest_phase_a");
    push(t0 + 4, 1, 4, "rest_phase_b");
    push(t0 + 7, 1, 10, "rest_phase_c");
    wait_until(t0 + 9);

    // Clamp and Db/Dr increment arithmetic, then fill the ring with nonzero data
    do_reset(t0);
    for (int j = 0; j < 10; j++) begin
      wait_until(t0 + j);
      even_line = b_even[j][0];
      dev_in    = 13'(b_dev[j]);
      enabled   = b_en[j][0];
      push(t0 + j + 2, 0, b_exp[j], "clamp_inc");
    end
    wait_until(t0 + 10);
    enabled = 1'b1; even_line = 1'b1; dev_in = 13'sd500;
    wait_until(t0 + 46);

    // Alignment delay of 5 clocks; stale ring contents must not be read
    do_reset(t0);
    enabled = 1'b1; even_line = 1'b1; dev_in = '0; latency = 5'd5;
    push(t0 + 8, 1, 12, "delay_pre");
    push(t0 + 11, 0, 'h1000, "delay_pia_before");
    push(t0 + 12, 0, 'h1320, "delay_pia_step");
    push(t0 + 17, 1, 30, "delay_cp17");
    push(t0 + 18, 1, 0, "delay_cp18");
    push(t0 + 19, 1, 2, "delay_cp19");
    push(t0 + 20, 1, 4, "delay_cp20");
    push(t0 + 21, 1, 7, "delay_cp21");
    push(t0 + 22, 1, 9, "delay_cp22");
    wait_until(t0 + 10);
    dev_in = 13'sd50;
    wait_until(t0 + 24);

    // Envelope: fall mid-ramp, re-enable from IDLE and mid ramp-down
    do_reset(t0);
    for (int k = 0; k < 22; k++) push(t0 + d_off[k], 2, d_exp[k], "envelope");
    enabled = 1'b1;
    wait_until(t0 + 4);  enabled = 1'b0;
    wait_until(t0 + 10); enabled = 1'b1;
    wait_until(t0 + 14); enabled = 1'b0;
    wait_until(t0 + 17); enabled = 1'b1;
    wait_until(t0 + 23); ampl_in = 6'd10;
    wait_until(t0 + 26);

    // Line/frame phase sequence
    do_reset(t0);
    for (int k = 0; k < 10; k++) push(t0 + e_off[k], 1, e_exp[k], "phase_seq");
    wait_until(t0 + 2);  pulse(1'b0, 1'b1);
    wait_until(t0 + 4);  pulse(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_until(t0 + 7 + 3 * k);
      pulse(1'b1, 1'b0);
    end
    wait_until(t0 + 21); pulse(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_until(t0 + 23 + 3 * k);
      pulse(1'b1, 1'b0);
    end
    wait_until(t0 + 34);

    repeat (4) tick();
    while (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: check for cycle %0d never performed, required 0x%0h",
               sb[0].name, sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
